uart_rx_frame: RTL

UART receive deserializer that sits directly upstream of the receive FIFO. It oversamples the serial input at 16x baud, assembles 8N1 or 8-parity-1 frames and checks parity and framing. It also detects line breaks. Each completed frame is pushed as an 11-bit FIFO word: {data[7:0], break, parity_error, framing_error}. The FIFO handles full and overrun; this block never stalls.

---
 rtl/uart_rx_frame.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receive deserializer: 8N1 / 8-parity-1 framing, parity,
// framing and line-break detection, one 11-bit word pushed per completed frame.
module uart_rx_frame #(
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_POINT = 7
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        enable,
  input  logic        srx_pad_i,
  input  logic        rx_en,
  input  logic        lcr_pen,
  input  logic        lcr_eps,
  output logic [10:0] rf_data_in,
  output logic        rf_push,
  output logic        rx_busy,
  output logic        break_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_PUSH
  } state_e;

  localparam logic [3:0] SAMPLE_TCNT = 4'(SAMPLE_POINT);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [3:0]             tcnt_q, tcnt_d;
  logic [2:0]             bcnt_q, bcnt_d;
  logic [7:0]             data_q, data_d;
  logic                   pbit_q, pbit_d;
  logic                   pen_q, pen_d;
  logic                   eps_q, eps_d;
  logic                   fe_q, fe_d;
  logic                   pe_q, pe_d;
  logic                   brk_q, brk_d;
  logic [10:0]            rf_data_q, rf_data_d;
  logic                   rf_push_q, rf_push_d;
  logic                   break_active_q, break_active_d;

  // Synchronizer resets to the idle (high) line level so no false start follows reset.
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], srx_pad_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_q        <= S_IDLE;
      tcnt_q         <= '0;
      bcnt_q         <= '0;
      data_q         <= '0;
      pbit_q         <= 1'b0;
      pen_q          <= 1'b0;
      eps_q          <= 1'b0;
      fe_q           <= 1'b0;
      pe_q           <= 1'b0;
      brk_q          <= 1'b0;
      rf_data_q      <= '0;
      rf_push_q      <= 1'b0;
      break_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tcnt_q         <= tcnt_d;
      bcnt_q         <= bcnt_d;
      data_q         <= data_d;
      pbit_q         <= pbit_d;
      pen_q          <= pen_d;
      eps_q          <= eps_d;
      fe_q           <= fe_d;
      pe_q           <= pe_d;
      brk_q          <= brk_d;
      rf_data_q      <= rf_data_d;
      rf_push_q      <= rf_push_d;
      break_active_q <= break_active_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tcnt_d         = tcnt_q;
    bcnt_d         = bcnt_q;
    data_d         = data_q;
    pbit_d         = pbit_q;
    pen_d          = pen_q;
    eps_d          = eps_q;
    fe_d           = fe_q;
    pe_d           = pe_q;
    brk_d          = brk_q;
    rf_data_d      = rf_data_q;
    rf_push_d      = 1'b0;
    break_active_d = break_active_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          // After a break the line must return high before a new start is accepted.
          if (break_active_q) begin
            if (rx_s) begin
              break_active_d = 1'b0;
            end
          end else if (rx_en && !rx_s) begin
            tcnt_d  = '0;
            pen_d   = lcr_pen;
            eps_d   = lcr_eps;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        if (enable) begin
          if (tcnt_q == SAMPLE_TCNT) begin
            tcnt_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              bcnt_d  = '0;
              pbit_d  = 1'b0;
              state_d = S_DATA;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (enable) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            data_d = {rx_s, data_q[7:1]};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              state_d = pen_q ? S_PARITY : S_STOP;
            end
          end
        end
      end

      S_PARITY: begin
        if (enable) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            pbit_d  = rx_s;
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (enable) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            brk_d   = (data_q == 8'h00) && !(pen_q && pbit_q) && !rx_s;
            fe_d    = !rx_s;
            pe_d    = pen_q ? (eps_q ? (^{data_q, pbit_q}) : (~^{data_q, pbit_q})) : 1'b0;
            state_d = S_PUSH;
          end
        end
      end

      S_PUSH: begin
        rf_push_d      = 1'b1;
        rf_data_d      = {data_q, brk_q, pe_q, fe_q};
        break_active_d = brk_q;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Receiver disable discards any partially assembled frame.
    if (!rx_en && (state_q inside {S_START, S_DATA, S_PARITY, S_STOP})) begin
      state_d = S_IDLE;
      tcnt_d  = '0;
      bcnt_d  = '0;
      data_d  = '0;
      pbit_d  = 1'b0;
    end
  end

  assign rf_data_in   = rf_data_q;
  assign rf_push      = rf_push_q;
  assign rx_busy      = (state_q != S_IDLE);
  assign break_active = break_active_q;

endmodule
